// File: rtl/maxpool_layer.sv
// maxpool_layer: 2x2 stride-2 signed max pooling over one conv channel, one window per clock.
// Define MAXPOOL_RELU_EN to clamp negative window maxima to zero before the write.
module maxpool_layer #(
    parameter int IN_X      = 24,
    parameter int IN_Y      = 24,
    parameter int DATA_SIZE = 69
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   pool_enable,
    input  logic signed [IN_X-1:0][IN_Y-1:0][DATA_SIZE-1:0]        conv_result,
    output logic signed [IN_X/2-1:0][IN_Y/2-1:0][DATA_SIZE-1:0]    pool_result,
    output logic                                                   out_valid,
    output logic signed [DATA_SIZE-1:0]                            out_data,
    output logic [$clog2(IN_X/2)-1:0]                              out_row,
    output logic [$clog2(IN_Y/2)-1:0]                              out_col,
    output logic                                                   pool_done
);
    localparam int RW = $clog2(IN_X/2);
    localparam int CW = $clog2(IN_Y/2);
    localparam logic [RW-1:0] LAST_R = RW'(IN_X/2-1);
    localparam logic [CW-1:0] LAST_C = CW'(IN_Y/2-1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]                  r_state;
    logic [RW-1:0]               r_row;
    logic [CW-1:0]               r_col;
    logic signed [DATA_SIZE-1:0] w_a, w_b, w_c, w_d, w_ab, w_cd, w_max, w_out;
    logic                        w_last;

    always_comb begin
        w_a   = $signed(conv_result[{r_row, 1'b0}][{r_col, 1'b0}]);
        w_b   = $signed(conv_result[{r_row, 1'b0}][{r_col, 1'b1}]);
        w_c   = $signed(conv_result[{r_row, 1'b1}][{r_col, 1'b0}]);
        w_d   = $signed(conv_result[{r_row, 1'b1}][{r_col, 1'b1}]);
        w_ab  = (w_a > w_b) ? w_a : w_b;
        w_cd  = (w_c > w_d) ? w_c : w_d;
        w_max = (w_ab > w_cd) ? w_ab : w_cd;
`ifdef MAXPOOL_RELU_EN
        w_out = w_max[DATA_SIZE-1] ? '0 : w_max;
`else
        w_out = w_max;
`endif
        w_last = (r_row == LAST_R) && (r_col == LAST_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            pool_result <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_row     <= '0;
            out_col     <= '0;
            pool_done   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    pool_done <= 1'b0;
                    r_row     <= '0;
                    r_col     <= '0;
                    if (pool_enable) r_state <= S_SCAN;
                end
                S_SCAN: begin
                    if (!pool_enable) begin
                        r_state   <= S_IDLE;
                        pool_done <= 1'b0;
                    end else begin
                        pool_result[r_row][r_col] <= w_out;
                        out_valid <= 1'b1;
                        out_data  <= w_out;
                        out_row   <= r_row;
                        out_col   <= r_col;
                        if (w_last) begin
                            r_state   <= S_DONE;
                            pool_done <= 1'b1;
                        end else begin
                            r_col <= (r_col == LAST_C) ? '0 : r_col + 1'b1;
                            r_row <= (r_col == LAST_C) ? r_row + 1'b1 : r_row;
                        end
                    end
                end
                S_DONE: begin
                    if (!pool_enable) begin
                        r_state   <= S_IDLE;
                        pool_done <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/maxpool_layer.md
MAXPOOL_LAYER -- requirements
Module: maxpool_layer

Interface
REQ-001 Parameter IN_X, default 24, input feature-map rows; SHALL be even.
REQ-002 Parameter IN_Y, default 24, input feature-map columns; SHALL be even.
REQ-003 Parameter DATA_SIZE, default 69, signed element width for input and output.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 pool_enable  input  1  level start/hold request, driven from the upstream conv_done.
REQ-007 conv_result  input  signed [DATA_SIZE-1:0] [IN_X-1:0][IN_Y-1:0]  one convolution channel; the block instantiates once per channel.
REQ-008 pool_result  output  signed [DATA_SIZE-1:0] [IN_X/2-1:0][IN_Y/2-1:0]  registered pooled map.
REQ-009 out_valid  output  1  one-cycle strobe that qualifies out_data, out_row and out_col.
REQ-010 out_data  output  signed [DATA_SIZE-1:0]  pooled value just written.
REQ-011 out_row  output  [$clog2(IN_X/2)-1:0]  row index of out_data.
REQ-012 out_col  output  [$clog2(IN_Y/2)-1:0]  column index of out_data.
REQ-013 pool_done  output  1  full map written; registered.

Function
REQ-014 The FSM SHALL have three states, IDLE, SCAN and DONE, encoded in registers.
REQ-015 IDLE: pool_enable=1 at an edge -> SCAN, with row=0 and col=0; otherwise remain in IDLE.
REQ-016 SCAN: each edge processes one 2x2 window (r,c) from input rows 2r..2r+1 and columns 2c..2c+1, in row-major order.
REQ-017 Per window, the block SHALL write pool_result[r][c] = signed max of the 4 elements, post-processed per REQ-030/031.
REQ-018 On the same edge, out_valid=1, out_data equals the value written, out_row=r and out_col=c.
REQ-019 col SHALL wrap from IN_Y/2-1 to 0 and increment row at the same time.
REQ-020 On the edge that writes window (IN_X/2-1, IN_Y/2-1), the FSM SHALL enter DONE and set pool_done=1.
REQ-021 Latency: enable sampled at edge k -> first write at edge k+1 -> last write and pool_done=1 at edge k+(IN_X/2)*(IN_Y/2); for defaults that is edge k+144.
REQ-022 DONE: pool_done SHALL hold 1 and out_valid 0 while pool_enable=1; pool_enable=0 -> IDLE with pool_done=0.
REQ-023 Abort: pool_enable=0 at any SCAN edge -> IDLE, with no write on that edge, out_valid=0 and pool_done=0; already-written entries are retained.
REQ-024 A restart after an abort or after DONE SHALL begin again at window (0,0).
REQ-025 pool_result SHALL hold its last value in IDLE and DONE and SHALL be overwritten only by SCAN writes.
REQ-026 conv_result SHALL be stable throughout SCAN (the upstream block holds it while enabled); the block SHALL NOT latch it.
REQ-027 Ties between equal elements SHALL yield that equal value; comparisons SHALL be full DATA_SIZE signed with no truncation.

Reset
REQ-028 rst=1 at an edge SHALL force state=IDLE, row=col=0, all pool_result=0, out_valid=0, out_data=0, out_row=0, out_col=0 and pool_done=0.
REQ-029 rst SHALL take priority over pool_enable, including mid-SCAN and in DONE.

Configuration
REQ-030 With macro MAXPOOL_RELU_EN defined, a window maximum below 0 SHALL be written as 0 (ReLU fused ahead of the write), on both pool_result and out_data.
REQ-031 With MAXPOOL_RELU_EN undefined, the signed window maximum SHALL be written unmodified; FSM and timing SHALL be identical in both builds.

Verification
REQ-032 Reset then hold pool_enable=1 with conv_result[x][y]=x*24+y -> pool_result[r][c]=(2r+1)*24+2c+1, out_valid high for exactly 144 consecutive cycles, pool_done at edge k+144.
REQ-033 All inputs -5 except conv_result[0][0]=-2 -> pool_result[0][0]=0 with MAXPOOL_RELU_EN, or -2 without; all other entries 0 or -5 respectively.
REQ-034 Drop pool_enable after 10 writes -> IDLE, pool_done=0, entries 0..9 hold new data, entries 10..143 keep old data; re-raise -> first out_row=0 and out_col=0.
REQ-035 Assert rst in DONE and mid-SCAN -> all outputs 0 on the next cycle, and no out_valid until pool_enable is sampled high again.
REQ-036 Window holding 2^68-1 and -2^68 -> output 2^68-1 with no overflow or sign error.
REQ-037 Ordering check: a window with values {7,7,3,-1} -> output 7; out_col wraps 11->0 with out_row incrementing on the same cycle.
